// File: rtl/inst_sram_axi_rbridge.sv
// -----------------------------------------------------------------------------
// inst_sram_axi_rbridge
//
// Bridges the fetch stage's SRAM-like instruction request interface
// (req / addr_ok / data_ok) onto an AXI4 read-address / read-data channel
// pair. Only reads are carried on this path. Up to MAX_OUTSTANDING requests
// may be accepted before their data comes back. All requests share one AXI
// ID, so responses return in issue order and the returned word is passed
// straight through to fetch.
//
// Parameters
//   MAX_OUTSTANDING : accepted-but-not-returned request limit (1..3)
//   AXI_ID          : constant value driven on arid
//
// Ports
//   clk, resetn                 : clock, synchronous active-low reset
//   inst_sram_req/wr/size/addr  : fetch request (wstrb/wdata unused)
//   inst_sram_addr_ok           : request accepted this cycle
//   inst_sram_data_ok/rdata     : returned instruction word valid / value
//   ar*                         : AXI read-address channel (single beat)
//   r*                          : AXI read-data channel (rid/rresp/rlast unused)
// -----------------------------------------------------------------------------
module inst_sram_axi_rbridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // Outstanding limit at the counter's width. The counter is 2 bits, which
    // is why the limit is confined to 1..3.
    localparam logic [1:0] CNT_MAX = 2'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic        addr_ok;
    logic        data_ok;
    logic        ar_fire;

    // Fields that the read-only, single-ID, single-beat protocol does not
    // need. They are reduced into one signal so that they stay visibly
    // consumed.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

    assign ar_fire = arvalid & arready;

    // State register. A reset throws away any AR still waiting for its
    // handshake. The slave is reset at the same time, so nothing is left
    // to wait for.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An accepted request always spends at least one
    // cycle in AR_WAIT. As a result, back-to-back accepts are spaced two
    // cycles apart even when arready is held high.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (addr_ok) state_next = AR_WAIT;
            AR_WAIT: if (ar_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic. Acceptance compares against the registered count. This
    // means a data_ok arriving while full cannot open the gate in that same
    // cycle. A write request is never accepted.
    always_comb begin
        addr_ok = 1'b0;
        arvalid = 1'b0;
        case (state)
            IDLE:    addr_ok = inst_sram_req & ~inst_sram_wr & (cnt < CNT_MAX);
            AR_WAIT: arvalid = 1'b1;
            default: begin
                addr_ok = 1'b0;
                arvalid = 1'b0;
            end
        endcase
    end

    // Read data is only taken while a request is outstanding. Any beat that
    // arrives with nothing pending is left unacknowledged.
    assign rready  = (cnt != 2'd0);
    assign data_ok = rvalid & rready;

    // Outstanding counter. A simultaneous accept and return cancel out.
    // The gating on addr_ok and rready keeps the count inside 0..CNT_MAX.
    always_comb begin
        cnt_next = cnt;
        case ({addr_ok, data_ok})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Address and size are captured only in the accept cycle. They then
    // stay frozen through AR_WAIT, because AXI forbids changing them while
    // arvalid waits for arready. Fetch may change its request freely in the
    // meantime.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            araddr_q <= 32'd0;
            arsize_q <= 2'd0;
        end else if (addr_ok) begin
            araddr_q <= inst_sram_addr;
            arsize_q <= inst_sram_size;
        end
    end

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok;
    assign inst_sram_rdata   = rdata;

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

endmodule
